// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack memory subsystem: RAM geometry defaults
// and the boot loader's state encoding.
package hack_mem_pkg;

    localparam int unsigned HACK_DEPTH = 14;
    localparam int unsigned HACK_WIDTH = 16;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    function automatic int unsigned bytes_per_word(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/ram_loader_byte_packer.sv
// Packs an MSB-first byte stream into WIDTH-bit words; flags the byte that
// completes a word so the caller can schedule the write.
module byte_packer
    import hack_mem_pkg::*;
#(
    parameter int unsigned WIDTH = HACK_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             accept,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);

    localparam int unsigned   BYTES    = bytes_per_word(WIDTH);
    localparam int unsigned   IW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] shift_next;

    generate
        if (BYTES > 1) begin : g_multi
            assign shift_next = {word[WIDTH-9:0], data};
        end else begin : g_single
            assign shift_next = data;
        end
    endgenerate

    assign word_done = accept && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (accept) begin
            word <= shift_next;
            idx  <= word_done ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Boot loader: streams bytes from a valid/ready source into consecutive RAM
// words starting at a programmable base, keeping a running word checksum.
module ram_loader
    import hack_mem_pkg::*;
#(
    parameter int unsigned DEPTH = HACK_DEPTH,
    parameter int unsigned WIDTH = HACK_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DEPTH-1:0] base_addr,
    input  logic [DEPTH:0]   word_count,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [WIDTH-1:0] ram_in,
    output logic [DEPTH-1:0] ram_address,
    output logic             ram_load,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] checksum
);

    logic [1:0]       state;
    logic [DEPTH-1:0] addr;
    logic [DEPTH:0]   remaining;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] in_hold;
    logic [DEPTH-1:0] addr_hold;
    logic             accept;
    logic             clear;
    logic             word_done;

    assign accept = (state == COLLECT) && rx_valid;
    assign clear  = (state == IDLE) && start;

    byte_packer #(
        .WIDTH(WIDTH)
    ) u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .accept   (accept),
        .data     (rx_data),
        .word     (word),
        .word_done(word_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            sum       <= '0;
            in_hold   <= '0;
            addr_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= word_count;
                        sum       <= '0;
                        state     <= (word_count == '0) ? DONE : COLLECT;
                    end
                end
                COLLECT: begin
                    if (word_done) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    sum       <= sum + word;
                    addr      <= addr + DEPTH'(1);
                    remaining <= remaining - (DEPTH+1)'(1);
                    in_hold   <= word;
                    addr_hold <= addr;
                    state     <= (remaining == (DEPTH+1)'(1)) ? DONE : COLLECT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM pins show the live word/address only while writing, then hold them.
    assign ram_load    = (state == WRITE);
    assign ram_in      = ram_load ? word : in_hold;
    assign ram_address = ram_load ? addr : addr_hold;
    assign rx_ready    = (state == COLLECT);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign checksum    = sum;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: table vectors, random loads and
// reset corner cases against a word-level reference model of the RAM.
module tb_ram_loader;
    import hack_mem_pkg::*;

    localparam int unsigned DEPTH     = HACK_DEPTH;
    localparam int unsigned WIDTH     = HACK_WIDTH;
    localparam int unsigned RAM_WORDS = 1 << DEPTH;

    logic             clk;
    logic             reset;
    logic             start;
    logic [DEPTH-1:0] base_addr;
    logic [DEPTH:0]   word_count;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] ram_in;
    logic [DEPTH-1:0] ram_address;
    logic             ram_load;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] checksum;

    ram_loader #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .ram_in     (ram_in),
        .ram_address(ram_address),
        .ram_load   (ram_load),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM on the loader's write side.
    logic [WIDTH-1:0] mem [RAM_WORDS];
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

    typedef struct {
        int          cyc;
        logic [13:0] a;
        logic [15:0] d;
        logic        rdy;
        logic        bsy;
    } wr_ev_t;

    typedef struct {
        logic [13:0] a;
        logic [15:0] d;
    } exp_wr_t;

    typedef struct {
        logic [13:0]      base;
        logic [14:0]      cnt;
        logic [3:0][15:0] w;
        int               mode;
        bit               poke;
        logic [15:0]      cs;
    } vec_t;

    // Event log, written only by the negedge monitor.
    int     cyc = 0;
    wr_ev_t wr_log[$];
    int     done_log[$];

    always @(negedge clk) begin
        cyc++;
        if (ram_load) wr_log.push_back('{cyc, ram_address, ram_in, rx_ready, busy});
        if (done) done_log.push_back(cyc);
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_mem   [RAM_WORDS];
    bit          exp_valid [RAM_WORDS];
    logic [7:0]  bytes_buf [2*RAM_WORDS];
    exp_wr_t     exp_wr[$];
    vec_t        tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic start_load(input logic [13:0] b, input logic [14:0] c, output int sc);
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        @(posedge clk); #1;
        start = 1'b0;
        sc    = cyc;
    endtask

    // mode 0: always valid; 1: toggling with a 20-cycle gap after byte 0; 2: random
    task automatic drive_bytes(input int n, input int mode, input bit poke);
        int  i      = 0;
        int  gap    = 0;
        int  t      = 0;
        int  budget = 1000 + 4 * n;
        bit  poked  = 1'b0;
        bit  acc;
        while (i < n && t < budget) begin
            case (mode)
                0: rx_valid = 1'b1;
                1: begin
                    if (i == 1 && gap < 20) begin
                        rx_valid = 1'b0;
                        gap++;
                    end else begin
                        rx_valid = (t % 2 == 0);
                    end
                end
                default: rx_valid = ($urandom_range(0, 3) != 0);
            endcase
            rx_data = bytes_buf[i];
            if (poke && i == 1 && !poked) begin
                start      = 1'b1;
                base_addr  = 14'h0300;
                word_count = 15'd5;
                poked      = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            acc = rx_valid && rx_ready;
            @(posedge clk); #1;
            if (acc) i++;
            t++;
        end
        rx_valid = 1'b0;
        start    = 1'b0;
        check("byte_stream_accepted", 32'(i), 32'(n));
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        check("idle_after_done", {28'd0, busy, done, rx_ready, ram_load}, 32'd0);
    endtask

    task automatic compare_image();
        int mism = 0;
        for (int i = 0; i < int'(RAM_WORDS); i++)
            if (exp_valid[i] && mem[i] !== exp_mem[i]) mism++;
        check("ram_image_mismatches", 32'(mism), 32'd0);
    endtask

    task automatic run_load(input logic [13:0] base, input logic [14:0] cnt, input int mode,
                            input bit poke, input bit cs_known, input logic [15:0] cs_tbl);
        int          base_wr;
        int          base_done;
        int          sc;
        int          n;
        int          exp_done_cyc;
        logic [15:0] sum = '0;
        exp_wr_t     e;

        exp_wr.delete();
        for (int k = 0; k < int'(cnt); k++) begin
            e.a = 14'((int'(base) + k) % int'(RAM_WORDS));
            e.d = {bytes_buf[2*k], bytes_buf[2*k+1]};
            exp_wr.push_back(e);
            sum += e.d;
        end

        base_wr   = wr_log.size();
        base_done = done_log.size();
        start_load(base, cnt, sc);
        if (cnt != 0) drive_bytes(2 * int'(cnt), mode, poke);
        wait_done();

        n = wr_log.size() - base_wr;
        check("write_count", 32'(n), 32'(cnt));
        for (int k = 0; k < n && k < exp_wr.size(); k++) begin
            check("write_addr_data", {wr_log[base_wr+k].a, 2'b00, wr_log[base_wr+k].d},
                  {exp_wr[k].a, 2'b00, exp_wr[k].d});
            check("write_ctrl_rdy_busy", {30'd0, wr_log[base_wr+k].rdy, wr_log[base_wr+k].bsy},
                  32'd1);
            if (mode == 0)
                check("write_latency", 32'(wr_log[base_wr+k].cyc - sc), 32'(3 * (k + 1)));
        end

        exp_done_cyc = (n > 0) ? wr_log[base_wr+n-1].cyc + 1 : sc + 1;
        check("done_pulses", 32'(done_log.size() - base_done), 32'd1);
        if (done_log.size() > base_done)
            check("done_timing", 32'(done_log[base_done]), 32'(exp_done_cyc));

        check("checksum_model", {16'd0, checksum}, {16'd0, sum});
        if (cs_known) check("checksum_table", {16'd0, checksum}, {16'd0, cs_tbl});

        foreach (exp_wr[k]) begin
            exp_mem[exp_wr[k].a]   = exp_wr[k].d;
            exp_valid[exp_wr[k].a] = 1'b1;
        end
        compare_image();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          sc;
        int          base_wr;
        logic [13:0] rb;
        logic [14:0] rc;

        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        rx_data    = '0;
        rx_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_ready", 32'(rx_ready), 32'd0);
        check("reset_ram_load", 32'(ram_load), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ram_address", 32'(ram_address), 32'd0);
        check("reset_ram_in", 32'(ram_in), 32'd0);
        check("reset_checksum", 32'(checksum), 32'd0);
        reset = 1'b0;

        tbl[0] = '{14'h0010, 15'd3, {16'h1234, 16'hABCD, 16'h00FF, 16'h0000}, 0, 1'b0, 16'hBF00};
        tbl[1] = '{14'h0010, 15'd3, {16'h1234, 16'hABCD, 16'h00FF, 16'h0000}, 1, 1'b0, 16'hBF00};
        tbl[2] = '{14'h3FFF, 15'd2, {16'h1111, 16'h2222, 16'h0000, 16'h0000}, 0, 1'b0, 16'h3333};
        tbl[3] = '{14'h0100, 15'd0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, 1'b0, 16'h0000};
        tbl[4] = '{14'h0200, 15'd2, {16'hBEEF, 16'h0001, 16'h0000, 16'h0000}, 1, 1'b1, 16'hBEF0};

        // w[3] holds the first word of each vector.
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < int'(tbl[v].cnt); k++) begin
                bytes_buf[2*k]   = tbl[v].w[3-k][15:8];
                bytes_buf[2*k+1] = tbl[v].w[3-k][7:0];
            end
            run_load(tbl[v].base, tbl[v].cnt, tbl[v].mode, tbl[v].poke, 1'b1, tbl[v].cs);
        end

        // Reset after one byte of word 2 in a 4-word load over 0x0010.
        for (int k = 0; k < 4; k++) begin
            bytes_buf[2*k]   = 8'hAA + 8'(k * 17);
            bytes_buf[2*k+1] = 8'hAA + 8'(k * 17);
        end
        base_wr = wr_log.size();
        start_load(14'h0010, 15'd4, sc);
        drive_bytes(3, 0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("midload_reset_busy", 32'(busy), 32'd0);
        check("midload_reset_rx_ready", 32'(rx_ready), 32'd0);
        check("midload_reset_ram_load", 32'(ram_load), 32'd0);
        check("midload_reset_checksum", 32'(checksum), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("midload_write_count", 32'(wr_log.size() - base_wr), 32'd1);
        if (wr_log.size() > base_wr)
            check("midload_first_word", {wr_log[base_wr].a, 2'b00, wr_log[base_wr].d},
                  {14'h0010, 2'b00, 16'hAAAA});
        exp_mem[14'h0010] = 16'hAAAA;
        compare_image();

        // Reset while the WRITE cycle is on the pins.
        bytes_buf[0] = 8'h77;
        bytes_buf[1] = 8'h88;
        base_wr = wr_log.size();
        start_load(14'h0600, 15'd1, sc);
        drive_bytes(2, 0, 1'b0);
        check("write_cycle_before_reset", 32'(ram_load), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("write_reset_ram_load", 32'(ram_load), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("aborted_write_count", 32'(wr_log.size() - base_wr), 32'd0);

        bytes_buf[0] = 8'h5A;
        bytes_buf[1] = 8'hA5;
        run_load(14'h0500, 15'd1, 0, 1'b0, 1'b1, 16'h5AA5);

        for (int r = 0; r < 6; r++) begin
            rb = (r == 0) ? 14'h3FFE : 14'($urandom_range(0, RAM_WORDS - 1));
            rc = 15'($urandom_range(1, 6));
            for (int k = 0; k < 2 * int'(rc); k++) bytes_buf[k] = 8'($urandom);
            run_load(rb, rc, 2, 1'b0, 1'b0, 16'h0000);
        end

        // Whole RAM, wrapping back to the base.
        for (int k = 0; k < 2 * int'(RAM_WORDS); k++) bytes_buf[k] = 8'($urandom);
        run_load(14'h2A5A, 15'(RAM_WORDS), 0, 1'b0, 1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
